// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control slice.
//   FWD_*      : register-file port mux select encodings (ID/EX/MEM/WB)
//   shadow_t   : shadow copy of one pipeline stage's write-back info
//   hz_state_e : hazard controller FSM states
package mips_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                 rf_en;
    logic                 load;
    logic [REG_IDX_W-1:0] dest;
  } shadow_t;

  typedef enum logic {
    RUN    = 1'b0,
    STALL1 = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// fwd_select: combinational per-operand forwarding priority matcher.
//   uses       : operand is actually read by the ID instruction
//   src        : operand source register index
//   ex_e/mem_e/wb_e : shadow entries of the EX, MEM and WB stages
//   sel        : mux select, EX > MEM > WB priority, else ID
//   hz         : operand depends on a load whose data is not yet forwardable
module fwd_select
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1
) (
  input  logic                 uses,
  input  logic [REG_IDX_W-1:0] src,
  input  shadow_t              ex_e,
  input  shadow_t              mem_e,
  input  shadow_t              wb_e,
  output logic [1:0]           sel,
  output logic                 hz
);

  logic active;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic mem_fwd_ok;

  // $0 is hardwired zero: it never forwards and never stalls.
  assign active  = uses && (src != '0);
  assign ex_hit  = active && ex_e.rf_en  && (ex_e.dest  == src);
  assign mem_hit = active && mem_e.rf_en && (mem_e.dest == src);
  assign wb_hit  = active && wb_e.rf_en  && (wb_e.dest  == src);

  // With two-bubble loads the MEM stage has no load data yet, so a MEM load
  // is skipped and an older WB writer (if any) is used instead.
  assign mem_fwd_ok = (LOAD_USE_STALLS != 2) || !mem_e.load;

  always_comb begin
    sel = FWD_ID;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit && mem_fwd_ok) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  assign hz = (ex_hit && ex_e.load) ||
              ((LOAD_USE_STALLS == 2) && mem_hit && mem_e.load);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: hazard detection and forwarding control for the
// 5-stage MIPS core. Tracks dest/write-enable/load of EX, MEM and WB in a
// shadow pipeline, drives operand forwarding selects and load-use stalls.
//   clk, reset (sync, active-low)
//   ID_RS/ID_RT, ID_USES_RS/ID_USES_RT : operands of the ID instruction
//   ID_DEST, ID_RF_ENABLE, ID_LOAD_INSTR : write-back info of the ID instruction
//   FWD_SEL_A/FWD_SEL_B : port mux selects (00 ID, 01 EX, 10 MEM, 11 WB)
//   CONTROL_MUX : 1 = NOP control word into ID/EX
//   PC_LE, IF_ID_LE : load enables, 0 = hold
// Optional macro HAZARD_STALL_CNT_EN adds STALL_COUNT[31:0], a saturating
// count of bubble-injection cycles.
module hazard_forward_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned REG_W           = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic [REG_W-1:0] ID_DEST,
  input  logic             ID_RF_ENABLE,
  input  logic             ID_LOAD_INSTR,
  output logic [1:0]       FWD_SEL_A,
  output logic [1:0]       FWD_SEL_B,
  output logic             CONTROL_MUX,
  output logic             PC_LE,
  output logic             IF_ID_LE
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      STALL_COUNT
`endif
);

  shadow_t   ex_q, mem_q, wb_q;
  shadow_t   id_entry;
  hz_state_e state, next_state;
  logic [1:0] sel_a, sel_b;
  logic       hz_a, hz_b, hz;

  assign id_entry.rf_en = ID_RF_ENABLE;
  assign id_entry.load  = ID_LOAD_INSTR;
  assign id_entry.dest  = REG_IDX_W'(ID_DEST);

  fwd_select #(.LOAD_USE_STALLS(LOAD_USE_STALLS)) u_fwd_a (
    .uses  (ID_USES_RS),
    .src   (REG_IDX_W'(ID_RS)),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .sel   (sel_a),
    .hz    (hz_a)
  );

  fwd_select #(.LOAD_USE_STALLS(LOAD_USE_STALLS)) u_fwd_b (
    .uses  (ID_USES_RT),
    .src   (REG_IDX_W'(ID_RT)),
    .ex_e  (ex_q),
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .sel   (sel_b),
    .hz    (hz_b)
  );

  // RS and RT hazards on the same load collapse into a single stall.
  assign hz = hz_a || hz_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      state <= RUN;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= CONTROL_MUX ? shadow_t'('0) : id_entry;
      state <= next_state;
    end
  end

  // The stall length is not timed: STALL1 simply re-checks the hazard against
  // the advanced shadow stages, so a load moving EX->MEM keeps stalling only
  // while its data is still unavailable.
  always_comb begin
    next_state  = state;
    FWD_SEL_A   = sel_a;
    FWD_SEL_B   = sel_b;
    CONTROL_MUX = 1'b0;
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;

    case (state)
      RUN:     if (hz) next_state = (LOAD_USE_STALLS == 2) ? STALL1 : RUN;
      STALL1:  next_state = RUN;
      default: next_state = RUN;
    endcase

    if (hz) begin
      CONTROL_MUX = 1'b1;
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
    end

    if (!reset) begin
      next_state  = RUN;
      FWD_SEL_A   = FWD_ID;
      FWD_SEL_B   = FWD_ID;
      CONTROL_MUX = 1'b1;
      PC_LE       = 1'b0;
      IF_ID_LE    = 1'b0;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      STALL_COUNT <= '0;
    end else if (CONTROL_MUX && (STALL_COUNT != '1)) begin
      STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: one stimulus stream drives two
// instances (one- and two-bubble load variants); a reference model of the
// in-flight instructions predicts each cycle's outputs.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rfen;
    logic       load;
  } instr_t;

  typedef struct packed {
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        cm;
    logic        pc;
    logic        ifid;
  } outs_t;

  typedef struct packed {
    outs_t       o1;
    outs_t       o2;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic id_urs, id_urt, id_rfen, id_load;
  logic [1:0] sa1, sb1, sa2, sb2;
  logic cm1, pc1, ii1, cm2, pc2, ii2;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt1, cnt2;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_USE_STALLS(1), .REG_W(5)) dut1 (
    .clk(clk), .reset(reset),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_urs), .ID_USES_RT(id_urt),
    .ID_DEST(id_dest), .ID_RF_ENABLE(id_rfen), .ID_LOAD_INSTR(id_load),
    .FWD_SEL_A(sa1), .FWD_SEL_B(sb1), .CONTROL_MUX(cm1), .PC_LE(pc1),
    .IF_ID_LE(ii1)
`ifdef HAZARD_STALL_CNT_EN
    , .STALL_COUNT(cnt1)
`endif
  );

  hazard_forward_ctrl #(.LOAD_USE_STALLS(2), .REG_W(5)) dut2 (
    .clk(clk), .reset(reset),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(id_urs), .ID_USES_RT(id_urt),
    .ID_DEST(id_dest), .ID_RF_ENABLE(id_rfen), .ID_LOAD_INSTR(id_load),
    .FWD_SEL_A(sa2), .FWD_SEL_B(sb2), .CONTROL_MUX(cm2), .PC_LE(pc2),
    .IF_ID_LE(ii2)
`ifdef HAZARD_STALL_CNT_EN
    , .STALL_COUNT(cnt2)
`endif
  );

  // In-flight instructions, index 0 = EX, 1 = MEM, 2 = WB (zero = bubble).
  instr_t p1 [3];
  instr_t p2 [3];
  logic [31:0] cnt_model;

  // Youngest older writer of src wins; for lus=2 a load still in MEM has no
  // data yet and is passed over.
  function automatic logic [1:0] pick(input int lus, input logic use_it,
                                      input logic [4:0] src, input instr_t s [3]);
    if (!use_it || src == 5'd0) return 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (s[i].rfen && s[i].dest == src) begin
        if (!(lus == 2 && i == 1 && s[i].load)) return 2'(i + 1);
      end
    end
    return 2'd0;
  endfunction

  // Load data appears only once the load reaches stage index lus.
  function automatic logic must_stall(input int lus, input instr_t id, input instr_t s [3]);
    for (int i = 0; i < lus; i++) begin
      if (s[i].rfen && s[i].load && s[i].dest != 5'd0 &&
          ((id.urs && id.rs == s[i].dest) || (id.urt && id.rt == s[i].dest)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic outs_t predict(input int lus, input instr_t id, input logic rst_n,
                                    input instr_t s [3]);
    outs_t o;
    logic st;
    if (!rst_n) begin
      o = '{sa: 2'd0, sb: 2'd0, cm: 1'b1, pc: 1'b0, ifid: 1'b0};
    end else begin
      st = must_stall(lus, id, s);
      o.sa = pick(lus, id.urs, id.rs, s);
      o.sb = pick(lus, id.urt, id.rt, s);
      o.cm = st;
      o.pc = !st;
      o.ifid = !st;
    end
    return o;
  endfunction

  task automatic advance(input instr_t id, input logic rst_n, input logic bubble,
                         inout instr_t s [3]);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) s[i] = '0;
    end else begin
      s[2] = s[1];
      s[1] = s[0];
      s[0] = bubble ? instr_t'('0) : id;
    end
  endtask

  task automatic issue(input instr_t id, input logic rst_n);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst_n;
    id_rs   = id.rs;   id_rt   = id.rt;
    id_urs  = id.urs;  id_urt  = id.urt;
    id_dest = id.dest; id_rfen = id.rfen; id_load = id.load;
    e.o1 = predict(1, id, rst_n, p1);
    e.o2 = predict(2, id, rst_n, p2);
    e.cnt = cnt_model;
    sb_q.push_back(e);
    advance(id, rst_n, e.o1.cm, p1);
    advance(id, rst_n, e.o2.cm, p2);
    if (!rst_n) cnt_model = '0;
    else if (e.o1.cm && cnt_model != '1) cnt_model = cnt_model + 32'd1;
  endtask

  function automatic instr_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input int dest, input bit rfen, input bit load);
    instr_t t;
    t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
    t.dest = 5'(dest); t.rfen = rfen; t.load = load;
    return t;
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  int unsigned cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cyc++;
      checks++;
      if ({sa1, sb1, cm1, pc1, ii1} !== e.o1) begin
        errors++;
        $display("FAIL lus1 cyc %0d: got sa=%b sb=%b cm=%b pc=%b ifid=%b, want sa=%b sb=%b cm=%b pc=%b ifid=%b",
                 cyc, sa1, sb1, cm1, pc1, ii1, e.o1.sa, e.o1.sb, e.o1.cm, e.o1.pc, e.o1.ifid);
      end
      checks++;
      if ({sa2, sb2, cm2, pc2, ii2} !== e.o2) begin
        errors++;
        $display("FAIL lus2 cyc %0d: got sa=%b sb=%b cm=%b pc=%b ifid=%b, want sa=%b sb=%b cm=%b pc=%b ifid=%b",
                 cyc, sa2, sb2, cm2, pc2, ii2, e.o2.sa, e.o2.sb, e.o2.cm, e.o2.pc, e.o2.ifid);
      end
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      if (cnt1 !== e.cnt) begin
        errors++;
        $display("FAIL stall_count cyc %0d: got %0d want %0d", cyc, cnt1, e.cnt);
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  instr_t nop_i, sub_i, lw8;
  initial begin
    int unsigned waited;
    instr_t r;
    nop_i = '0;
    cnt_model = '0;
    for (int i = 0; i < 3; i++) begin p1[i] = '0; p2[i] = '0; end
    reset = 1'b0;
    {id_rs, id_rt, id_dest, id_urs, id_urt, id_rfen, id_load} = '0;

    repeat (3) issue(nop_i, 1'b0);

    // add $3,$1,$2 ; add $4,$3,$5
    issue(mk(1, 2, 1, 1, 3, 1, 0), 1'b1);
    issue(mk(3, 5, 1, 1, 4, 1, 0), 1'b1);
    repeat (3) issue(nop_i, 1'b1);

    // lw $8 ; nop ; add $9,$8,$8
    lw8 = mk(0, 8, 1, 0, 8, 1, 1);
    issue(lw8, 1'b1);
    issue(nop_i, 1'b1);
    issue(mk(8, 8, 1, 1, 9, 1, 0), 1'b1);
    repeat (3) issue(nop_i, 1'b1);

    // lw $8 ; sub $9,$8,$1 held in ID while stalled
    sub_i = mk(8, 1, 1, 1, 9, 1, 0);
    issue(lw8, 1'b1);
    repeat (3) issue(sub_i, 1'b1);
    repeat (3) issue(nop_i, 1'b1);

    // ori $0,$0,5 ; add $1,$0,$0
    issue(mk(0, 0, 1, 0, 0, 1, 0), 1'b1);
    issue(mk(0, 0, 1, 1, 1, 1, 0), 1'b1);
    repeat (3) issue(nop_i, 1'b1);

    // three writers to $7, then readers seeing EX, then MEM/WB only
    repeat (3) issue(mk(1, 2, 1, 1, 7, 1, 0), 1'b1);
    issue(mk(7, 7, 1, 1, 10, 1, 0), 1'b1);
    repeat (2) issue(mk(1, 2, 1, 1, 7, 1, 0), 1'b1);
    issue(nop_i, 1'b1);
    issue(mk(7, 7, 1, 1, 11, 1, 0), 1'b1);
    repeat (3) issue(nop_i, 1'b1);

    // load with both operands dependent: a single stall
    issue(lw8, 1'b1);
    issue(mk(8, 8, 1, 1, 12, 1, 0), 1'b1);
    issue(mk(8, 8, 1, 1, 12, 1, 0), 1'b1);
    // back-to-back dependent loads
    issue(lw8, 1'b1);
    issue(mk(8, 0, 1, 0, 9, 1, 1), 1'b1);
    repeat (2) issue(mk(9, 0, 1, 0, 10, 1, 0), 1'b1);
    repeat (3) issue(mk(9, 0, 1, 0, 10, 1, 0), 1'b1);

    // reset during a stall, then a reader of the old load target
    issue(lw8, 1'b1);
    issue(sub_i, 1'b1);
    issue(sub_i, 1'b0);
    issue(sub_i, 1'b1);
    issue(sub_i, 1'b1);
    repeat (2) issue(nop_i, 1'b1);

    // randomized traffic, small register range for frequent hits
    for (int n = 0; n < 500; n++) begin
      r.rs   = 5'($urandom_range(0, 5));
      r.rt   = 5'($urandom_range(0, 5));
      r.urs  = 1'($urandom_range(0, 1));
      r.urt  = 1'($urandom_range(0, 1));
      r.dest = 5'($urandom_range(0, 5));
      r.rfen = ($urandom_range(0, 9) < 7);
      r.load = r.rfen && ($urandom_range(0, 9) < 4);
      issue(r, ($urandom_range(0, 49) != 0));
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
